vend_dispense_arbiter: RTL and testbench

VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_stock_counter.sv | 32 +++
 rtl/vend_dispense_arbiter.sv | 151 +++++++++++++++
 tb/tb_vend_dispense_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared constants, state encoding and stock helper for the dispense arbiter
package vend_pkg;

  localparam int                 STOCK_W   = 4;
  localparam logic [STOCK_W-1:0] STOCK_MAX = 4'd15;

  localparam logic ITEM_SODA = 1'b0;
  localparam logic ITEM_DIET = 1'b1;

  // FSM encoding kept as plain constants so older blocks can compare raw bits
  typedef logic [1:0] vend_state_t;
  localparam vend_state_t ST_IDLE = 2'd0;
  localparam vend_state_t ST_RUN  = 2'd1;
  localparam vend_state_t ST_DONE = 2'd2;

  // Saturating add used by the restock path; the carry-out flags overflow past STOCK_MAX
  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STOCK_W] ? STOCK_MAX : sum[STOCK_W-1:0];
  endfunction

endpackage

// File: rtl/vend_stock_counter.sv
// rtl/vend_stock_counter.sv - saturating stock counter for one item
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count clears to 0)
//   dec         remove one unit (ignored at 0)
//   add, qty    add qty units, saturating at STOCK_MAX
//   cnt         current stock level
module vend_stock_counter
  import vend_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec,
  input  logic               add,
  input  logic [STOCK_W-1:0] qty,
  output logic [STOCK_W-1:0] cnt
);

  logic [STOCK_W-1:0] after_dec;

  // The decrement is taken first so a simultaneous restock saturates on the reduced level
  assign after_dec = (dec && cnt != '0) ? cnt - STOCK_W'(1) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (dec || add) begin
      cnt <= add ? sat_add(after_dec, qty) : after_dec;
    end
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// rtl/vend_dispense_arbiter.sv - two-panel round-robin vend arbiter with motor timing and stock tracking
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_a/req_b, item_a/item_b     panel requests and selected item (0 soda, 1 diet)
//   restock, restock_sel, restock_qty  service-port stock load
//   gnt_*, nack_*, done_*          one-cycle per-panel pulses
//   motor_en, motor_sel            motor drive and chute select
//   busy                           FSM outside IDLE
//   soda_cnt, diet_cnt             stock levels
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_a,
  input  logic               req_b,
  input  logic               item_a,
  input  logic               item_b,
  input  logic               restock,
  input  logic               restock_sel,
  input  logic [STOCK_W-1:0] restock_qty,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic               nack_a,
  output logic               nack_b,
  output logic               done_a,
  output logic               done_b,
  output logic               motor_en,
  output logic               motor_sel,
  output logic               busy,
  output logic [STOCK_W-1:0] soda_cnt,
  output logic [STOCK_W-1:0] diet_cnt
);

  vend_state_t state;
  logic [3:0]  motor_cnt;
  logic        rr_ptr;     // 0: panel A has priority on a tie, 1: panel B
  logic        owner_b;    // panel that owns the vend in flight

  logic        valid_a, valid_b;
  logic        empty_a, empty_b;
  logic        grant_any, pick_b, grant_item;
  logic        soda_dec, diet_dec, soda_add, diet_add;

  always_comb begin
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    empty_a    = 1'b0;
    empty_b    = 1'b0;
    // A request still held during its own nack cycle is the same request, so it is not re-judged
    if (state == ST_IDLE) begin
      if (req_a && !nack_a) begin
        if ((item_a ? diet_cnt : soda_cnt) != '0) valid_a = 1'b1;
        else                                      empty_a = 1'b1;
      end
      if (req_b && !nack_b) begin
        if ((item_b ? diet_cnt : soda_cnt) != '0) valid_b = 1'b1;
        else                                      empty_b = 1'b1;
      end
    end
    grant_any  = valid_a || valid_b;
    pick_b     = valid_b && (!valid_a || rr_ptr);
    grant_item = pick_b ? item_b : item_a;
    soda_dec   = grant_any && (grant_item == ITEM_SODA);
    diet_dec   = grant_any && (grant_item == ITEM_DIET);
    soda_add   = restock && (restock_sel == ITEM_SODA);
    diet_add   = restock && (restock_sel == ITEM_DIET);
  end

  vend_stock_counter u_soda (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (soda_dec),
    .add   (soda_add),
    .qty   (restock_qty),
    .cnt   (soda_cnt)
  );

  vend_stock_counter u_diet (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (diet_dec),
    .add   (diet_add),
    .qty   (restock_qty),
    .cnt   (diet_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      motor_cnt <= '0;
      rr_ptr    <= 1'b0;
      owner_b   <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      nack_a    <= 1'b0;
      nack_b    <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      motor_en  <= 1'b0;
      motor_sel <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      nack_a <= empty_a;
      nack_b <= empty_b;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state     <= ST_RUN;
            gnt_a     <= !pick_b;
            gnt_b     <= pick_b;
            owner_b   <= pick_b;
            motor_en  <= 1'b1;
            motor_sel <= grant_item;
            // The grant cycle is the first motor cycle, so the count starts one short
            motor_cnt <= 4'(MOTOR_CYCLES - 1);
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (motor_cnt == '0) begin
            state    <= ST_DONE;
            motor_en <= 1'b0;
            done_a   <= !owner_b;
            done_b   <= owner_b;
            rr_ptr   <= !rr_ptr;
          end else begin
            motor_cnt <= motor_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          motor_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// tb/tb_vend_dispense_arbiter.sv - self-checking bench for the dispense arbiter
module tb_vend_dispense_arbiter;

  localparam int MC = 4;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, item_a, item_b;
  logic       restock, restock_sel;
  logic [3:0] restock_qty;
  logic       gnt_a, gnt_b, nack_a, nack_b, done_a, done_b;
  logic       motor_en, motor_sel, busy;
  logic [3:0] soda_cnt, diet_cnt;

  int errors = 0;
  int checks = 0;

  vend_dispense_arbiter #(.MOTOR_CYCLES(MC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_a       (req_a),
    .req_b       (req_b),
    .item_a      (item_a),
    .item_b      (item_b),
    .restock     (restock),
    .restock_sel (restock_sel),
    .restock_qty (restock_qty),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .nack_a      (nack_a),
    .nack_b      (nack_b),
    .done_a      (done_a),
    .done_b      (done_b),
    .motor_en    (motor_en),
    .motor_sel   (motor_sel),
    .busy        (busy),
    .soda_cnt    (soda_cnt),
    .diet_cnt    (diet_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a vend is a numbered sequence of cycles (1..MC motor, MC+1 done)
  int       m_k;
  int       m_owner;
  bit       m_ptr;
  bit       m_sel;
  int       m_stock[2];
  bit [1:0] e_gnt, e_nack, e_done;

  function automatic void model_reset();
    m_k = 0; m_owner = 0; m_ptr = 0; m_sel = 0;
    m_stock[0] = 0; m_stock[1] = 0;
    e_gnt = 0; e_nack = 0; e_done = 0;
  endfunction

  function automatic void model_step();
    bit rq[2];
    bit it[2];
    bit v[2];
    int w;
    int nk;
    rq[0] = req_a; rq[1] = req_b; it[0] = item_a; it[1] = item_b;
    e_gnt = 0; e_nack = 0; e_done = 0;
    nk = 0;
    if (m_k == 0) begin
      for (int i = 0; i < 2; i++) begin
        v[i] = rq[i] && (m_stock[it[i]] > 0);
        if (rq[i] && m_stock[it[i]] == 0) e_nack[i] = 1'b1;
      end
      if (v[0] || v[1]) begin
        w = (v[0] && v[1]) ? int'(m_ptr) : (v[1] ? 1 : 0);
        e_gnt[w] = 1'b1;
        m_owner = w;
        m_sel = it[w];
        m_stock[it[w]] = m_stock[it[w]] - 1;
        nk = 1;
      end
    end else if (m_k < MC + 1) begin
      nk = m_k + 1;
    end
    if (nk == MC + 1) begin
      e_done[m_owner] = 1'b1;
      m_ptr = !m_ptr;
    end
    if (restock) begin
      m_stock[restock_sel] = m_stock[restock_sel] + int'(restock_qty);
      if (m_stock[restock_sel] > 15) m_stock[restock_sel] = 15;
    end
    m_k = nk;
  endfunction

  function automatic logic [15:0] act_vec();
    return {gnt_a, gnt_b, nack_a, nack_b, done_a, done_b, motor_en, busy, soda_cnt, diet_cnt};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic me;
    me = (m_k >= 1) && (m_k <= MC);
    return {e_gnt[0], e_gnt[1], e_nack[0], e_nack[1], e_done[0], e_done[1], me, (m_k != 0),
            4'(m_stock[0]), 4'(m_stock[1])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    check("model", 32'(act_vec()), 32'(exp_vec()));
    if (m_k >= 1 && m_k <= MC) check("motor_sel", 32'(motor_sel), 32'(m_sel));
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; item_a = 0; item_b = 0;
    restock = 0; restock_sel = 0; restock_qty = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(act_vec()), 32'h0);
    check("reset_sel", 32'(motor_sel), 32'h0);
    rst_n = 1;
    model_reset();
  endtask

  task automatic load(input bit sel, input int qty);
    restock = 1; restock_sel = sel; restock_qty = 4'(qty);
    cyc();
    restock = 0;
  endtask

  typedef struct {
    logic       rs, rsel;
    logic [3:0] qty;
    logic       ra, ia, rb, ib;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input logic rs, input logic rsel, input int qty,
                              input logic ra, input logic ia, input logic rb, input logic ib,
                              input logic [7:0] flags, input int soda, input int diet);
    vec_t v;
    v.rs = rs; v.rsel = rsel; v.qty = 4'(qty);
    v.ra = ra; v.ia = ia; v.rb = rb; v.ib = ib;
    v.exp = {flags, 4'(soda), 4'(diet)};
    tbl.push_back(v);
  endfunction

  // flags: {gnt_a, gnt_b, nack_a, nack_b, done_a, done_b, motor_en, busy}
  initial begin
    int order[$];
    bit seen_nack_b;
    bit seen_gnt_b;
    bit seen_done;
    int guard;

    rst_n = 0;
    idle_inputs();
    model_reset();

    row(1, 0, 3,  0, 0, 0, 0, 8'b0000_0000, 3, 0);
    row(0, 0, 0,  1, 0, 0, 0, 8'b1000_0011, 2, 0);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 2, 0);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 2, 0);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 2, 0);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_1001, 2, 0);
    row(1, 0, 3,  0, 0, 0, 0, 8'b0000_0000, 5, 0);
    row(0, 0, 0,  1, 0, 1, 1, 8'b1001_0011, 4, 0);
    row(1, 1, 10, 0, 0, 0, 0, 8'b0000_0011, 4, 10);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 4, 10);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 4, 10);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_1001, 4, 10);
    row(1, 1, 9,  0, 0, 0, 0, 8'b0000_0000, 4, 15);
    row(1, 0, 12, 0, 0, 0, 0, 8'b0000_0000, 15, 15);
    row(1, 0, 3,  1, 0, 0, 0, 8'b1000_0011, 15, 15);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 15, 15);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 15, 15);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0011, 15, 15);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_1001, 15, 15);
    row(0, 0, 0,  0, 0, 0, 0, 8'b0000_0000, 15, 15);

    do_reset();
    foreach (tbl[i]) begin
      restock = tbl[i].rs; restock_sel = tbl[i].rsel; restock_qty = tbl[i].qty;
      req_a = tbl[i].ra; item_a = tbl[i].ia; req_b = tbl[i].rb; item_b = tbl[i].ib;
      cyc();
      check($sformatf("table_row%0d", i), 32'(act_vec()), 32'(tbl[i].exp));
      if (tbl[i].exp[9]) check($sformatf("table_sel%0d", i), 32'(motor_sel), 32'h0);
    end
    idle_inputs();

    // Both panels want the last soda: A wins, B is then refused once the vend finishes
    do_reset();
    load(0, 1);
    load(1, 1);
    req_a = 1; item_a = 0; req_b = 1; item_b = 0;
    cyc();
    check("tie_gnt_a", 32'({gnt_a, gnt_b}), 32'b10);
    req_a = 0;
    seen_nack_b = 0; seen_gnt_b = 0; guard = 0;
    while (!seen_nack_b && guard < 20) begin
      cyc();
      if (gnt_b) seen_gnt_b = 1;
      if (nack_b) begin seen_nack_b = 1; req_b = 0; end
      guard++;
    end
    check("tie_nack_b_seen", 32'(seen_nack_b), 32'h1);
    check("tie_no_gnt_b", 32'(seen_gnt_b), 32'h0);
    check("tie_soda_zero", 32'(soda_cnt), 32'h0);
    idle_inputs();

    // Both panels hold requests continuously: grants alternate A, B, A
    do_reset();
    load(0, 5);
    load(1, 5);
    req_a = 1; item_a = 0; req_b = 1; item_b = 1;
    guard = 0;
    while (order.size() < 3 && guard < 40) begin
      cyc();
      if (gnt_a) order.push_back(0);
      if (gnt_b) order.push_back(1);
      guard++;
    end
    check("rr_count", 32'(order.size()), 32'd3);
    if (order.size() >= 3) begin
      check("rr_order0", 32'(order[0]), 32'd0);
      check("rr_order1", 32'(order[1]), 32'd1);
      check("rr_order2", 32'(order[2]), 32'd0);
    end
    idle_inputs();
    repeat (2 * MC + 4) cyc();

    // Reset in the second motor cycle aborts the vend with no done pulse
    do_reset();
    load(0, 2);
    req_a = 1; item_a = 0;
    cyc();
    check("abort_gnt", 32'(gnt_a), 32'h1);
    req_a = 0;
    cyc();
    check("abort_run2_motor", 32'(motor_en), 32'h1);
    #3;
    rst_n = 0;
    #1;
    check("abort_now", 32'({motor_en, busy, done_a, done_b, soda_cnt, diet_cnt}), 32'h0);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_a || done_b || motor_en) seen_done = 1;
    end
    rst_n = 1;
    model_reset();
    repeat (MC + 3) begin
      cyc();
      if (done_a || done_b) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'h0);

    // Random panel traffic and restocks against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (req_a && (gnt_a || nack_a)) req_a = 0;
      else if (!req_a && $urandom_range(0, 2) == 0) begin req_a = 1; item_a = 1'($urandom_range(0, 1)); end
      if (req_b && (gnt_b || nack_b)) req_b = 0;
      else if (!req_b && $urandom_range(0, 2) == 0) begin req_b = 1; item_b = 1'($urandom_range(0, 1)); end
      restock     = ($urandom_range(0, 5) == 0);
      restock_sel = 1'($urandom_range(0, 1));
      restock_qty = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
